// File: rtl/cadence_torque_cond.sv
// Sensor-conditioning front end: synchronizes the crank pulse, counts pedal edges per
// fixed window, and exponentially averages raw torque samples for the assist path.
module cadence_torque_cond #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cadence_raw,
  input  logic [11:0] torque,
  input  logic        torque_vld,
  output logic [11:0] avg_torque,
  output logic [4:0]  cadence,
  output logic        not_pedaling,
  output logic        cadence_upd
);

  localparam int WIN_W = FAST_SIM ? 12 : 24;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             hist_q, hist_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       cadence_q, cadence_d;
  logic             np_q, np_d;
  logic             upd_q, upd_d;
  logic             seed_q, seed_d;
  logic [15:0]      acc_q, acc_d;

  logic             rise;
  logic             terminal;
  logic             np_fall;
  logic [4:0]       cnt_inc;
  logic [16:0]      acc_filt;

  // Crank pulse path: two-flop synchronizer plus a history flop for edge detect.
  always_comb begin
    sync1_d = cadence_raw;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    rise    = sync2_q & ~hist_q;
  end

  // Window timer, edge counter and window-end register loads.
  always_comb begin
    win_d     = win_q + WIN_ONE;
    terminal  = &win_q;
    cnt_inc   = (rise && (cnt_q != 5'd31)) ? cnt_q + 5'd1 : cnt_q;
    cnt_d     = cnt_inc;
    cadence_d = cadence_q;
    np_d      = np_q;
    upd_d     = 1'b0;
    if (terminal) begin
      // An edge seen in the terminal cycle still belongs to the closing window.
      cadence_d = cnt_inc;
      np_d      = (cnt_inc < 5'd2);
      upd_d     = 1'b1;
      cnt_d     = 5'd0;
    end
    np_fall = np_q & ~np_d;
  end

  // Torque filter: acc tracks 16x the average; the first sample after a seed
  // request replaces the history instead of blending into it.
  always_comb begin
    acc_filt = {1'b0, acc_q} - {5'b0, acc_q[15:4]} + {5'b0, torque};
    acc_d    = acc_q;
    seed_d   = seed_q;
    if (torque_vld) begin
      if (seed_q) begin
        acc_d  = {torque, 4'h0};
        seed_d = 1'b0;
      end else if (acc_filt[16]) begin
        // Unreachable for 12-bit inputs; guards against any future widening.
        acc_d = 16'hFFFF;
      end else begin
        acc_d = acc_filt[15:0];
      end
    end
    // A sample coincident with the fall is filtered; the seed takes the next one.
    if (np_fall) begin
      seed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      win_q     <= '0;
      cnt_q     <= 5'd0;
      cadence_q <= 5'd0;
      np_q      <= 1'b1;
      upd_q     <= 1'b0;
      seed_q    <= 1'b1;
      acc_q     <= 16'h0000;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      cadence_q <= cadence_d;
      np_q      <= np_d;
      upd_q     <= upd_d;
      seed_q    <= seed_d;
      acc_q     <= acc_d;
    end
  end

  assign avg_torque   = acc_q[15:4];
  assign cadence      = cadence_q;
  assign not_pedaling = np_q;
  assign cadence_upd  = upd_q;

endmodule
